// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   state_t   : responder FSM states (IDLE, WAIT, RESP)
//   CNT_W     : width of the latency down-counter (LATENCY is 1..15)
//   idx_width : word-index width for a given storage depth (log2)
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 4;

  function automatic int unsigned idx_width(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: single port, per-byte write enable,
// registered read. Contents are not reset.
//   clk   : clock
//   rd_en : capture mem[idx] into rdata on this edge
//   wr_be : per-byte write enables for mem[idx]
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (holds until the next rd_en)
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned IDX_W       = 14
) (
  input  logic             clk,
  input  logic             rd_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    if (rd_en) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-port responder with fixed access latency.
// One request at a time over req_valid/req_ready; the response is returned
// over resp_valid/resp_ready so the pipeline can stall on it.
// Optional feature macro: DMEM_BYTE_STROBE_EN (adds req_wstrb byte enables).
//   clk        : clock
//   reset      : asynchronous reset, active low
//   req_valid  : request present          req_ready  : can accept request
//   req_write  : 1 = store, 0 = load      req_addr   : byte address
//   req_wdata  : store data               req_wstrb  : byte enables (macro only)
//   resp_valid : response present         resp_ready : requester takes response
//   resp_rdata : load data (0 for stores / errors)
//   resp_err   : misaligned access
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 16384,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned IDX_W = idx_width(DEPTH_WORDS);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             wr_q;
  logic             err_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;
  logic             load_q;

  logic [3:0]       req_be;
  logic             req_err;
  logic [IDX_W-1:0] req_idx;
  logic             unused_addr_hi;

`ifdef DMEM_BYTE_STROBE_EN
  // Only full-word accesses are alignment-checked; partial strobes may
  // target any byte address and the low address bits are ignored.
  assign req_be  = req_wstrb;
  assign req_err = (req_wstrb == 4'hF) && (req_addr[1:0] != 2'b00);
`else
  assign req_be  = 4'hF;
  assign req_err = (req_addr[1:0] != 2'b00);
`endif

  // Upper address bits are ignored: accesses wrap modulo DEPTH_WORDS*4.
  assign req_idx        = req_addr[IDX_W+1:2];
  assign unused_addr_hi = ^req_addr[31:IDX_W+2];

  logic accept;
  logic go_resp;
  assign accept  = (state == IDLE) && req_valid;
  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // array is fed from the live request instead of the latched copy.
  assign go_resp = (accept && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == CNT_W'(1)));

  logic             a_write;
  logic             a_err;
  logic [IDX_W-1:0] a_idx;
  logic [31:0]      a_wdata;
  logic [3:0]       a_be;

  always_comb begin
    a_write = wr_q;
    a_err   = err_q;
    a_idx   = idx_q;
    a_wdata = wdata_q;
    a_be    = be_q;
    if (state == IDLE) begin
      a_write = req_write;
      a_err   = req_err;
      a_idx   = req_idx;
      a_wdata = req_wdata;
      a_be    = req_be;
    end
  end

  // Array enables are gated by reset so nothing commits while it is held.
  logic        arr_rd_en;
  logic [3:0]  arr_be;
  logic [31:0] arr_rdata;

  assign arr_rd_en = go_resp && reset && !a_write && !a_err;
  assign arr_be    = (go_resp && reset && a_write && !a_err) ? a_be : '0;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .rd_en (arr_rd_en),
    .wr_be (arr_be),
    .idx   (a_idx),
    .wdata (a_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      load_q   <= 1'b0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            err_q   <= req_err;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= RESP;
        end
        RESP: begin
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        load_q   <= !a_write && !a_err;
        resp_err <= a_err;
      end
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  // Array read register is unreset; load_q selects it only for good loads.
  assign resp_rdata = load_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH = 16384;
  localparam int          LAT   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  wstrb = 4'hF;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  // Reference model: word storage keyed by word index.
  logic [31:0] model [int];

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb  (wstrb),
`endif
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int widx(input logic [31:0] addr);
    return int'((addr / 4) % DEPTH);
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input logic [3:0] strb);
`ifdef DMEM_BYTE_STROBE_EN
    return (strb == 4'hF) && (addr % 4 != 0);
`else
    return (addr % 4 != 0);
`endif
  endfunction

  // Returns the expected response data and updates the model.
  function automatic logic [31:0] model_access(input bit wr, input logic [31:0] addr,
                                               input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] old;
    logic [31:0] nw;
    if (model_err(addr, strb)) return 32'h0;
    old = model.exists(widx(addr)) ? model[widx(addr)] : 32'hx;
    if (!wr) return old;
`ifndef DMEM_BYTE_STROBE_EN
    strb = 4'hF;
`endif
    nw = old;
    for (int b = 0; b < 4; b++) if (strb[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
    model[widx(addr)] = nw;
    return 32'h0;
  endfunction

  // Drives one request, waits (bounded) for the response and completes the
  // handshake. lat = number of cycles after acceptance until resp_valid (-1 = timeout).
  task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, output int lat,
                        output logic [31:0] rd, output logic err);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (resp_valid) begin lat = i; break; end
      @(negedge clk);
    end
    rd = resp_rdata; err = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d cycles with activity, want 0", seen);
    end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic err; logic [31:0] exp;
    exp = model_access(1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
    do_txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, lat, rd, err);
    checks++;
    if (lat != LAT || rd !== exp || err !== 1'b0) begin
      errors++;
      $display("FAIL store_0x100: lat=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=0", lat, rd, err, LAT, exp);
    end
    exp = model_access(1'b0, 32'h100, 32'h0, 4'hF);
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, lat, rd, err);
    checks++;
    if (lat != LAT || rd !== 32'hDEADBEEF || rd !== exp || err !== 1'b0) begin
      errors++;
      $display("FAIL load_0x100: lat=%0d rdata=%h err=%b, want lat=%0d rdata=deadbeef err=0", lat, rd, err, LAT);
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic err; logic [31:0] exp;
    int bad_data, bad_ready, waited;
    exp = model_access(1'b0, 32'h100, 32'h0, 4'hF);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_wdata = '0; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    // A competing store is presented while busy; it must be ignored.
    req_write = 1'b1; req_wdata = 32'hFFFFFFFF;
    waited = 0;
    while (!resp_valid && waited < 40) begin @(negedge clk); waited++; end
    checks++;
    if (!resp_valid || resp_rdata !== exp) begin
      errors++;
      $display("FAIL bp_first: valid=%b rdata=%h, want 1 %h", resp_valid, resp_rdata, exp);
    end
    bad_data = 0; bad_ready = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== exp || resp_err !== 1'b0) bad_data++;
      if (req_ready !== 1'b0) bad_ready++;
    end
    checks++;
    if (bad_data != 0) begin
      errors++;
      $display("FAIL bp_stable: %0d unstable cycles, want 0", bad_data);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL bp_req_ready: %0d cycles with req_ready=1, want 0", bad_ready);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, want 0 1", resp_valid, req_ready);
    end
    exp = model_access(1'b0, 32'h100, 32'h0, 4'hF);
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, lat, rd, err);
    checks++;
    if (lat != LAT || rd !== exp) begin
      errors++;
      $display("FAIL bp_ignored_store: lat=%0d rdata=%h, want lat=%0d rdata=%h", lat, rd, LAT, exp);
    end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rd; logic err; logic [31:0] exp;
    exp = model_access(1'b1, 32'h102, 32'h12345678, 4'hF);
    do_txn(1'b1, 32'h102, 32'h12345678, 4'hF, lat, rd, err);
    checks++;
    if (lat != LAT || err !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("FAIL misaligned_store: lat=%0d err=%b rdata=%h, want lat=%0d err=1 rdata=0", lat, err, rd, LAT);
    end
    exp = model_access(1'b0, 32'h100, 32'h0, 4'hF);
    do_txn(1'b0, 32'h100, 32'h0, 4'hF, lat, rd, err);
    checks++;
    if (rd !== exp || rd !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_no_commit: rdata=%h err=%b, want deadbeef 0", rd, err);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [31:0] rd; logic err; logic [31:0] exp;
    exp = model_access(1'b1, 32'h10000, 32'hCAFEF00D, 4'hF);
    do_txn(1'b1, 32'h10000, 32'hCAFEF00D, 4'hF, lat, rd, err);
    exp = model_access(1'b0, 32'h0, 32'h0, 4'hF);
    do_txn(1'b0, 32'h0, 32'h0, 4'hF, lat, rd, err);
    checks++;
    if (rd !== exp || rd !== 32'hCAFEF00D || err !== 1'b0) begin
      errors++;
      $display("FAIL addr_wrap: rdata=%h err=%b, want cafef00d 0", rd, err);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic err; logic [31:0] exp;
    exp = model_access(1'b1, 32'h200, 32'h55AA55AA, 4'hF);
    do_txn(1'b1, 32'h200, 32'h55AA55AA, 4'hF, lat, rd, err);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h200; req_wdata = 32'h0BADF00D; wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_outputs: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               req_ready, resp_valid, resp_rdata, resp_err);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp = model_access(1'b0, 32'h200, 32'h0, 4'hF);
    do_txn(1'b0, 32'h200, 32'h0, 4'hF, lat, rd, err);
    checks++;
    if (lat != LAT || rd !== exp || rd !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL reset_abort_no_commit: lat=%0d rdata=%h, want lat=%0d rdata=55aa55aa", lat, rd, LAT);
    end
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_strobe();
    int lat; logic [31:0] rd; logic err; logic [31:0] exp;
    exp = model_access(1'b1, 32'h300, 32'h11223344, 4'hF);
    do_txn(1'b1, 32'h300, 32'h11223344, 4'hF, lat, rd, err);
    exp = model_access(1'b1, 32'h301, 32'h0000AB00, 4'b0010);
    do_txn(1'b1, 32'h301, 32'h0000AB00, 4'b0010, lat, rd, err);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL strobe_partial_err: err=%b, want 0", err);
    end
    exp = model_access(1'b0, 32'h300, 32'h0, 4'hF);
    do_txn(1'b0, 32'h300, 32'h0, 4'hF, lat, rd, err);
    checks++;
    if (rd !== exp || rd !== 32'h1122AB44) begin
      errors++;
      $display("FAIL strobe_merge: rdata=%h, want 1122ab44", rd);
    end
  endtask
`endif

  task automatic test_random();
    int lat; logic [31:0] rd; logic err; logic [31:0] exp; bit experr;
    logic [31:0] addr; logic [31:0] wd; logic [3:0] strb; bit wr;
    for (int i = 0; i < 8; i++) begin
      wd = $urandom;
      exp = model_access(1'b1, 32'h400 + 32'(i * 4), wd, 4'hF);
      do_txn(1'b1, 32'h400 + 32'(i * 4), wd, 4'hF, lat, rd, err);
    end
    for (int n = 0; n < 40; n++) begin
      wr   = $urandom_range(0, 1);
      // Base word, optional alias via ignored upper bits, occasional misalignment.
      addr = 32'h400 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3)) * 32'h10000;
      if ($urandom_range(0, 5) == 0) addr = addr + 32'($urandom_range(1, 3));
      wd   = $urandom;
`ifdef DMEM_BYTE_STROBE_EN
      strb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
`else
      strb = 4'hF;
`endif
      experr = model_err(addr, strb);
      exp    = model_access(wr, addr, wd, strb);
      do_txn(wr, addr, wd, strb, lat, rd, err);
      checks++;
      if (lat != LAT || rd !== exp || err !== experr) begin
        errors++;
        $display("FAIL random_%0d: wr=%b addr=%h lat=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=%b",
                 n, wr, addr, lat, rd, err, LAT, exp, experr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_backpressure();
    test_misaligned();
    test_wrap();
    test_reset_abort();
`ifdef DMEM_BYTE_STROBE_EN
    test_strobe();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
